// File: rtl/psum_accumulator_if.sv
// AXI-Stream style beat bundle (data, valid/ready, last, id) shared by the
// input and output sides of the partial-sum accumulator.
interface psum_accumulator_if #(
  parameter int DATA_W = 16,
  parameter int ID_W   = 1
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [ID_W-1:0]   tid;

  modport master (output tdata, output tvalid, output tlast, output tid, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tid, output tready);
endinterface

// File: rtl/psum_accumulator.sv
// Per-lane partial-sum accumulator: sums signed beats up to tlast in a guard-bit
// extended register, saturates to OUT_WIDTH and emits one framed result beat.
module psum_accumulator #(
  parameter int RSLT_WIDTH        = 16,
  parameter int GUARD_BITS        = 8,
  parameter int OUT_WIDTH         = 16,
  parameter int RESULTS_PER_FRAME = 4,
  parameter int ID_WIDTH          = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  psum_accumulator_if.slave    s_axis,
  psum_accumulator_if.master   m_axis,
  output logic                 err_overflow,
  output logic                 err_id_mismatch
);

  localparam int ACC_WIDTH = RSLT_WIDTH + GUARD_BITS;
  localparam int CNT_W     = (RESULTS_PER_FRAME > 1) ? $clog2(RESULTS_PER_FRAME) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RESULTS_PER_FRAME - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;

  state_t                         state_q, state_d;
  logic signed [ACC_WIDTH-1:0]    acc_p0;
  logic        [ID_WIDTH-1:0]     tid_p0;
  logic        [OUT_WIDTH-1:0]    res_p1;
  logic        [CNT_W-1:0]        frame_cnt;
  logic signed [RSLT_WIDTH-1:0]   din_p0;
  logic signed [ACC_WIDTH-1:0]    din_ext;
  logic signed [ACC_WIDTH-1:0]    sum_c;
  logic                           in_fire;
  logic                           out_fire;
  logic                           first_beat;

  function automatic logic sat_ovf(input logic signed [ACC_WIDTH-1:0] v);
    return (v > SAT_MAX) || (v < SAT_MIN);
  endfunction

  function automatic logic [OUT_WIDTH-1:0] saturate(input logic signed [ACC_WIDTH-1:0] v);
    if (v > SAT_MAX)      return SAT_MAX[OUT_WIDTH-1:0];
    else if (v < SAT_MIN) return SAT_MIN[OUT_WIDTH-1:0];
    else                  return v[OUT_WIDTH-1:0];
  endfunction

  assign s_axis.tready = (state_q != OUTPUT);
  assign in_fire       = s_axis.tvalid && s_axis.tready;
  assign out_fire      = m_axis.tvalid && m_axis.tready;
  assign first_beat    = (state_q == IDLE);

  // Final-sum path: a new sum restarts from the incoming beat instead of acc.
  assign din_p0  = s_axis.tdata;
  assign din_ext = ACC_WIDTH'(din_p0);
  assign sum_c   = first_beat ? din_ext : acc_p0 + din_ext;

  assign m_axis.tvalid = (state_q == OUTPUT);
  assign m_axis.tdata  = res_p1;
  assign m_axis.tid    = tid_p0;
  assign m_axis.tlast  = (state_q == OUTPUT) && (frame_cnt == LAST_CNT);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, ACCUM: if (in_fire) state_d = s_axis.tlast ? OUTPUT : ACCUM;
      OUTPUT:      if (m_axis.tready) state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      acc_p0          <= '0;
      tid_p0          <= '0;
      res_p1          <= '0;
      frame_cnt       <= '0;
      err_overflow    <= 1'b0;
      err_id_mismatch <= 1'b0;
    end else begin
      state_q <= state_d;
      // Stage p0: accumulate and track the id of the first beat.
      if (in_fire) begin
        acc_p0 <= sum_c;
        if (first_beat)
          tid_p0 <= s_axis.tid;
        else if (s_axis.tid != tid_p0)
          err_id_mismatch <= 1'b1;
        // Stage p1: saturated result registered with the tlast beat.
        if (s_axis.tlast) begin
          res_p1 <= saturate(sum_c);
          if (sat_ovf(sum_c)) err_overflow <= 1'b1;
        end
      end
      if (out_fire)
        frame_cnt <= (frame_cnt == LAST_CNT) ? '0 : frame_cnt + 1'b1;
    end
  end

endmodule
